// File: rtl/key_repeat_if.sv
`default_nettype none
// ============================================================================
// Module      : key_repeat_if
// Description : Button-level inputs and game-action event outputs of one
//               key_repeat instance (one per movement button).
// Revision    : 1.0 - initial release
// ============================================================================
interface key_repeat_if;
  logic level_in;       // debounced button level, 1 = held
  logic enable;         // 1 = generate events, 0 = suppress and idle
  logic press_pulse;    // one cycle on an accepted new press
  logic repeat_pulse;   // one cycle per auto-repeat
  logic move_pulse;     // press_pulse | repeat_pulse
  logic release_pulse;  // one cycle when a tracked press ends
  logic held;           // 1 while a press is being tracked

  // Driver side: supplies the button level and enable, consumes events
  modport master (
    output level_in,
    output enable,
    input  press_pulse,
    input  repeat_pulse,
    input  move_pulse,
    input  release_pulse,
    input  held
  );

  // Key-repeat side: consumes the button level, produces events
  modport slave (
    input  level_in,
    input  enable,
    output press_pulse,
    output repeat_pulse,
    output move_pulse,
    output release_pulse,
    output held
  );
endinterface
`default_nettype wire

// File: rtl/key_repeat.sv
`default_nettype none
// ============================================================================
// Module      : key_repeat
// Description : Delayed-auto-shift key repeater. Converts a debounced button
//               level into one press pulse, a train of repeat pulses after an
//               initial hold delay, and one release pulse. All outputs are
//               registered.
// Revision    : 1.0 - initial release
// ============================================================================
module key_repeat #(
  parameter int DAS_CYCLES = 8_333_333,  // hold time before first repeat, >= 2
  parameter int ARR_CYCLES = 2_500_000,  // period between repeats, >= 2
  parameter int CNT_W      = 24          // 2**CNT_W > max(DAS, ARR)
) (
  input  wire            clock,
  input  wire            resetn,
  key_repeat_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // Terminal counts: the counter runs 0..LAST, so a repeat lands exactly
  // DAS_CYCLES (resp. ARR_CYCLES) edges after the previous event.
  localparam logic [CNT_W-1:0] c_DAS_LAST = CNT_W'(DAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_ARR_LAST = CNT_W'(ARR_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_prev_level;
  logic             r_press;
  logic             r_repeat;
  logic             r_move;
  logic             r_release;
  logic             r_held;

  logic             w_rise;

  assign w_rise = bus.level_in & ~r_prev_level;

  // Previous-level tracker. It samples even while reset is asserted, so a
  // button already held when reset lifts is never mistaken for a new press.
  always_ff @(posedge clock) begin
    r_prev_level <= bus.level_in;
  end

  // Main FSM: state, hold/repeat counter and all registered event outputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_press   <= 1'b0;
      r_repeat  <= 1'b0;
      r_move    <= 1'b0;
      r_release <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      // Pulses are single-cycle unless set below
      r_press   <= 1'b0;
      r_repeat  <= 1'b0;
      r_move    <= 1'b0;
      r_release <= 1'b0;

      if (!bus.enable) begin
        // Disabled: drop any tracked press silently (no release event)
        r_state <= ST_IDLE;
        r_count <= '0;
        r_held  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            // Only a genuine rising edge starts a press; a level that was
            // already high (e.g. across a disable) is ignored.
            if (w_rise) begin
              r_press <= 1'b1;
              r_move  <= 1'b1;
              r_state <= ST_DELAY;
              r_count <= '0;
              r_held  <= 1'b1;
            end else begin
              r_held  <= 1'b0;
            end
          end

          ST_DELAY: begin
            // Release is checked first so it wins over a coinciding repeat
            if (!bus.level_in) begin
              r_release <= 1'b1;
              r_state   <= ST_IDLE;
              r_count   <= '0;
              r_held    <= 1'b0;
            end else if (r_count == c_DAS_LAST) begin
              r_repeat  <= 1'b1;
              r_move    <= 1'b1;
              r_state   <= ST_REPEAT;
              r_count   <= '0;
              r_held    <= 1'b1;
            end else begin
              r_count   <= r_count + 1'b1;
              r_held    <= 1'b1;
            end
          end

          ST_REPEAT: begin
            if (!bus.level_in) begin
              r_release <= 1'b1;
              r_state   <= ST_IDLE;
              r_count   <= '0;
              r_held    <= 1'b0;
            end else if (r_count == c_ARR_LAST) begin
              r_repeat  <= 1'b1;
              r_move    <= 1'b1;
              r_count   <= '0;
              r_held    <= 1'b1;
            end else begin
              r_count   <= r_count + 1'b1;
              r_held    <= 1'b1;
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_held  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.press_pulse   = r_press;
  assign bus.repeat_pulse  = r_repeat;
  assign bus.move_pulse    = r_move;
  assign bus.release_pulse = r_release;
  assign bus.held          = r_held;

endmodule
`default_nettype wire

// File: tb/tb_key_repeat.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_repeat
// Description : Directed self-checking bench for key_repeat with
//               DAS_CYCLES=10, ARR_CYCLES=4. Each step drives one clock edge
//               and compares {press,repeat,move,release,held} afterwards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_repeat;

  localparam int c_DAS = 10;
  localparam int c_ARR = 4;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  key_repeat_if bus ();

  key_repeat #(
    .DAS_CYCLES (c_DAS),
    .ARR_CYCLES (c_ARR),
    .CNT_W      (24)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Expected output word {press, repeat, move, release, held}
  function automatic logic [4:0] ev(input logic p, input logic r,
                                    input logic rel, input logic h);
    return {p, r, p | r, rel, h};
  endfunction

  task automatic check(input string tag, input logic [4:0] obs,
                       input logic [4:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (press,repeat,move,release,held)",
               tag, obs, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then compare the registered outputs
  task automatic step(input string tag, input logic rstn, input logic lvl,
                      input logic en, input logic [4:0] exp);
    resetn       = rstn;
    bus.level_in = lvl;
    bus.enable   = en;
    @(posedge clock);
    #1;
    check(tag, {bus.press_pulse, bus.repeat_pulse, bus.move_pulse,
                bus.release_pulse, bus.held}, exp);
  endtask

  initial begin
    bus.level_in = 1'b1;
    bus.enable   = 1'b1;

    // ---- Reset with level held high through deassertion ----
    for (int i = 0; i < 3; i++) step("rst_hold", 1'b0, 1'b1, 1'b1, 5'b0);
    for (int i = 0; i < 4; i++) step("post_rst_high", 1'b1, 1'b1, 1'b1, 5'b0);
    step("post_rst_low", 1'b1, 1'b0, 1'b1, 5'b0);
    step("post_rst_press", 1'b1, 1'b1, 1'b1, ev(1, 0, 0, 1));
    step("post_rst_rel", 1'b1, 1'b0, 1'b1, ev(0, 0, 1, 0));
    step("post_rst_idle", 1'b1, 1'b0, 1'b1, 5'b0);

    // ---- Long hold: E0..E0+29 high, low at E0+30 (release beats repeat) ----
    for (int i = 0; i <= 31; i++) begin
      logic p, r, rel, h;
      p   = (i == 0);
      r   = (i == 10) || (i == 14) || (i == 18) || (i == 22) || (i == 26);
      rel = (i == 30);
      h   = (i < 30);
      step($sformatf("long_hold_%0d", i), 1'b1, (i < 30), 1'b1,
           ev(p, r, rel, h));
    end

    // ---- Short hold of 5 edges, then immediate re-press after release ----
    for (int i = 0; i <= 9; i++) begin
      logic lvl;
      lvl = (i < 5) || (i == 6) || (i == 7);
      step($sformatf("short_%0d", i), 1'b1, lvl, 1'b1,
           ev((i == 0) || (i == 6), 1'b0, (i == 5) || (i == 8),
              (i < 5) || (i == 6) || (i == 7)));
    end

    // ---- Release exactly at DAS terminal: release only, no repeat ----
    for (int i = 0; i <= 11; i++) begin
      step($sformatf("das_edge_%0d", i), 1'b1, (i < 10), 1'b1,
           ev((i == 0), 1'b0, (i == 10), (i < 10)));
    end

    // ---- Enable dropped at E0+12, raised at E0+20 with level still high ----
    for (int i = 0; i <= 28; i++) begin
      logic lvl, en;
      lvl = (i <= 24) || (i == 26);
      en  = !((i >= 12) && (i < 20));
      step($sformatf("enable_%0d", i), 1'b1, lvl, en,
           ev((i == 0) || (i == 26), (i == 10), (i == 27),
              (i < 12) || (i == 26)));
    end

    // ---- Reset asserted mid-DELAY at E0+5 with level held ----
    for (int i = 0; i <= 14; i++) begin
      logic rstn, lvl;
      rstn = !((i == 5) || (i == 6));
      lvl  = (i <= 10) || (i == 12);
      step($sformatf("mid_rst_%0d", i), rstn, lvl, 1'b1,
           ev((i == 0) || (i == 12), 1'b0, (i == 13), (i < 5) || (i == 12)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
